// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : sequential signed ALU with valid/ready handshakes.
//
// One operand set is accepted when in_valid && in_ready. ADD, SUB, AND, OR and
// unsupported opcodes finish in a single cycle. MUL (and DIV when enabled) run
// one iteration per cycle for WIDTH+1 cycles. The result is held in DONE until
// out_ready is seen high.
//
// Optional feature: define ALU_SEQ_DIV_EN to add signed restoring division
// (op 3'b110). When the macro is undefined, op 3'b110 is unsupported and no
// divider logic is built.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set presented
//   in_ready   block accepts an operand set this cycle (IDLE only)
//   in1, in2   signed WIDTH-bit operands
//   op         001 ADD, 010 SUB, 011 MUL, 100 AND, 101 OR, 110 DIV (optional)
//   out_valid  result and flags valid (DONE only)
//   out_ready  consumer takes the result
//   out        signed WIDTH-bit result
//   flags      {negative, zero, carry, overflow}
//   busy       high whenever the block is not IDLE
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             busy
);

    // Internal results carry one extra bit above the operand width.
    localparam int RW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_MUL = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_DIV = 3'b110
    } op_t;

    // {N, Z, C, V}: carry is the extension bit, overflow is set when the
    // extension bit disagrees with the WIDTH-bit sign bit.
    function automatic logic [3:0] calc_flags(input logic [RW-1:0] r);
        return {r[WIDTH-1], (r == '0), r[WIDTH], r[WIDTH] ^ r[WIDTH-1]};
    endfunction

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [3:0]      flags_q, flags_d;
    logic [2:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Shift-add multiplier state.
    logic [RW-1:0]   mcand_q, mcand_d;
    logic [RW-1:0]   mplier_q, mplier_d;
    logic [RW-1:0]   acc_q, acc_d;

`ifdef ALU_SEQ_DIV_EN
    // Restoring divider state, operating on magnitudes.
    logic [RW-1:0]   quo_q, quo_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [RW-1:0]   dvsr_q, dvsr_d;
    logic            neg_q, neg_d;
    logic            dz_q, dz_d;
    logic [RW:0]     rem_sh;
    logic [RW:0]     rem_sub;
`endif

    logic [RW-1:0]   a_ext, b_ext;
    logic [RW-1:0]   quick_res;
    logic [RW-1:0]   fin_res;
    logic            is_iter;

    assign a_ext = {in1[WIDTH-1], in1};
    assign b_ext = {in2[WIDTH-1], in2};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        flags_d     = flags_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        quick_res   = '0;
        fin_res     = '0;
        is_iter     = (op == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvsr_d      = dvsr_q;
        neg_d       = neg_q;
        dz_d        = dz_q;
        rem_sh      = {rem_q, quo_q[WIDTH]};
        rem_sub     = rem_sh - {1'b0, dvsr_q};
        is_iter     = (op == OP_MUL) || (op == OP_DIV);
`endif

        case (op)
            OP_ADD:  quick_res = a_ext + b_ext;
            OP_SUB:  quick_res = a_ext - b_ext;
            OP_AND:  quick_res = a_ext & b_ext;
            OP_OR:   quick_res = a_ext | b_ext;
            default: quick_res = '0;
        endcase

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d = op;
                    if (is_iter) begin
                        state_d  = BUSY;
                        cnt_d    = '0;
                        mcand_d  = a_ext;
                        mplier_d = b_ext;
                        acc_d    = '0;
`ifdef ALU_SEQ_DIV_EN
                        // Magnitudes fit in RW bits even for the most
                        // negative WIDTH-bit operand.
                        quo_d  = a_ext[WIDTH] ? -a_ext : a_ext;
                        dvsr_d = b_ext[WIDTH] ? -b_ext : b_ext;
                        rem_d  = '0;
                        neg_d  = a_ext[WIDTH] ^ b_ext[WIDTH];
                        dz_d   = (in2 == '0);
`endif
                    end else begin
                        state_d = DONE;
                        out_d   = quick_res[WIDTH-1:0];
                        flags_d = calc_flags(quick_res);
                    end
                end
            end

            BUSY: begin
                // One multiplier bit per cycle; sums wrap modulo 2^RW, which
                // gives the signed product truncated to RW bits.
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
`ifdef ALU_SEQ_DIV_EN
                // A clear top bit of rem_sub means the shifted remainder is
                // at least the divisor, so that quotient bit is 1.
                if (!rem_sub[RW]) begin
                    rem_d = rem_sub[RW-1:0];
                    quo_d = {quo_q[WIDTH-1:0], 1'b1};
                end else begin
                    rem_d = rem_sh[RW-1:0];
                    quo_d = {quo_q[WIDTH-1:0], 1'b0};
                end
`endif
                cnt_d = cnt_q + CW'(1);

                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    case (op_q)
                        OP_MUL:  fin_res = acc_d;
`ifdef ALU_SEQ_DIV_EN
                        OP_DIV:  fin_res = neg_q ? -quo_d : quo_d;
`endif
                        default: fin_res = '0;
                    endcase
                    out_d   = fin_res[WIDTH-1:0];
                    flags_d = calc_flags(fin_res);
`ifdef ALU_SEQ_DIV_EN
                    if (op_q == OP_DIV && dz_q) begin
                        out_d   = '0;
                        flags_d = 4'b0101;
                    end
`endif
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples values from before the edge.
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
`ifdef ALU_SEQ_DIV_EN
            quo_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            neg_q       <= 1'b0;
            dz_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_q       <= out_d;
            flags_q     <= flags_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
`ifdef ALU_SEQ_DIV_EN
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvsr_q      <= dvsr_d;
            neg_q       <= neg_d;
            dz_q        <= dz_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out       = out_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq : directed self-checking bench for alu_seq at WIDTH=16.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic [2:0]       op = 3'b000;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out;
    logic [3:0]       flags;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int lat;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set in IDLE, then count edges until out_valid.
    task automatic issue(input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] b, output int n);
        op       = o;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_rel_out_valid"}, out_valid, 1'b0);
        check({tag, "_rel_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        // Reset state.
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out", out, 16'h0000);
        check("rst_flags", flags, 4'b0000);
        rst = 1'b0;
        tick();

        // ADD overflow into the sign bit.
        issue(3'b001, 16'h7FFF, 16'h0001, lat);
        check("add_lat", lat, 1);
        check("add_out", out, 16'h8000);
        check("add_flags", flags, 4'b1001);
        check("add_in_ready", in_ready, 1'b0);
        check("add_busy", busy, 1'b1);
        take_result("add");

        // MUL whose product spills into the extension bit.
        issue(3'b011, 16'h0100, 16'h0100, lat);
        check("mul1_lat", lat, 18);
        check("mul1_out", out, 16'h0000);
        check("mul1_flags", flags, 4'b0011);
        take_result("mul1");

        // MUL with a negative operand.
        issue(3'b011, 16'hFFFD, 16'h0004, lat);
        check("mul2_lat", lat, 18);
        check("mul2_out", out, 16'hFFF4);
        check("mul2_flags", flags, 4'b1010);
        take_result("mul2");

`ifdef ALU_SEQ_DIV_EN
        issue(3'b110, 16'hFFF9, 16'h0002, lat);
        check("div_lat", lat, 18);
        check("div_out", out, 16'hFFFD);
        check("div_flags", flags, 4'b1010);
        take_result("div");

        issue(3'b110, 16'h0005, 16'h0000, lat);
        check("div0_lat", lat, 18);
        check("div0_out", out, 16'h0000);
        check("div0_flags", flags, 4'b0101);
        take_result("div0");
`else
        issue(3'b110, 16'h0007, 16'h0002, lat);
        check("op6_lat", lat, 1);
        check("op6_out", out, 16'h0000);
        check("op6_flags", flags, 4'b0100);
        take_result("op6");
`endif

        // AND, SUB with carry, unsupported opcodes.
        issue(3'b100, 16'hF0F0, 16'h0FF0, lat);
        check("and_out", out, 16'h00F0);
        check("and_flags", flags, 4'b0000);
        take_result("and");

        issue(3'b010, 16'h8000, 16'h0001, lat);
        check("sub_out", out, 16'h7FFF);
        check("sub_flags", flags, 4'b0011);
        take_result("sub");

        issue(3'b000, 16'h1234, 16'h5678, lat);
        check("op0_lat", lat, 1);
        check("op0_out", out, 16'h0000);
        check("op0_flags", flags, 4'b0100);
        take_result("op0");

        // SUB 5-5 held in DONE; new operands offered meanwhile are ignored.
        issue(3'b010, 16'h0005, 16'h0005, lat);
        op       = 3'b001;
        in1      = 16'h0011;
        in2      = 16'h0022;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_out", out, 16'h0000);
            check("hold_flags", flags, 4'b0100);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_busy", busy, 1'b1);
            check("hold_out_valid", out_valid, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        take_result("hold");
        check("hold_idle_busy", busy, 1'b0);
        check("hold_idle_out", out, 16'h0000);

        // OR leaves a nonzero result that must persist through a later BUSY.
        issue(3'b101, 16'h8000, 16'h0001, lat);
        check("or_out", out, 16'h8001);
        check("or_flags", flags, 4'b1010);
        take_result("or");

        // MUL aborted by reset at BUSY cycle 7.
        op       = 3'b011;
        in1      = 16'h0003;
        in2      = 16'h0003;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("abort_busy", busy, 1'b1);
        check("abort_in_ready", in_ready, 1'b0);
        check("abort_keep_out", out, 16'h8001);
        check("abort_keep_flags", flags, 4'b1010);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_idle_busy", busy, 1'b0);
        check("abort_idle_in_ready", in_ready, 1'b1);
        check("abort_out", out, 16'h0000);
        check("abort_flags", flags, 4'b0000);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) lat++;
        end
        check("abort_no_result", lat, 0);

        issue(3'b001, 16'h0002, 16'h0003, lat);
        check("add2_lat", lat, 1);
        check("add2_out", out, 16'h0005);
        check("add2_flags", flags, 4'b0000);

        // Reset wins over out_ready and in_valid in the same cycle.
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("prio_out_valid", out_valid, 1'b0);
        check("prio_busy", busy, 1'b0);
        check("prio_out", out, 16'h0000);
        tick();
        check("prio_no_accept", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; legal values 2..64.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 in1, in2  input  WIDTH each  signed two's-complement operands.
REQ-008 op  input  3  001 ADD, 010 SUB, 011 MUL, 100 AND, 101 OR, 110 DIV (only with the Configuration macro); others unsupported.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 out  output  WIDTH  signed result.
REQ-012 flags  output  4  {negative, zero, carry, overflow}.
REQ-013 busy  output  1  high whenever the block is not IDLE.

Function
REQ-014 FSM states: IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-015 Accept = in_valid && in_ready; in1, in2 and op are registered on accept and ignored otherwise.
REQ-016 On accept: ADD, SUB, AND, OR and unsupported ops go IDLE->DONE; MUL and DIV go IDLE->BUSY.
REQ-017 BUSY lasts exactly WIDTH+1 cycles, one iteration per cycle, then goes to DONE.
REQ-018 Latency, counted from the accepting edge to the edge raising out_valid: 1 for single-cycle ops, WIDTH+2 for MUL/DIV.
REQ-019 Arithmetic uses a (WIDTH+1)-bit internal result formed from sign-extended operands: ADD sum, SUB in1-in2, AND/OR bitwise, unsupported = 0.
REQ-020 MUL internal result = signed product truncated to WIDTH+1 bits (iterative shift-add over WIDTH+1 multiplier bits).
REQ-021 out = internal result [WIDTH-1:0].
REQ-022 Flags come from internal bits [WIDTH:WIDTH-1]: 00 -> N0 C0 V0; 01 -> N1 C0 V1; 10 -> N0 C1 V1; 11 -> N1 C1 V0.
REQ-023 zero = 1 iff the full (WIDTH+1)-bit internal result is 0.
REQ-024 out_valid = 1 only in DONE; out and flags stay stable in DONE until out_ready.
REQ-025 DONE with out_ready=1 goes to IDLE next edge; out_valid drops and in_ready rises in the same cycle.
REQ-026 No new accept while BUSY or DONE; a transaction completes only when out_ready is sampled high.
REQ-027 out and flags keep their last value outside DONE.

Reset
REQ-028 rst sampled high forces IDLE, out_valid=0, busy=0, out=0, flags=0000 and clears iteration counters; in_ready=1 the cycle after.
REQ-029 rst during BUSY or DONE aborts the transaction; the result is discarded and never presented.
REQ-030 rst has priority over in_valid and out_ready in the same cycle.

Configuration
REQ-031 Macro ALU_SEQ_DIV_EN defined: op 110 = signed restoring division over WIDTH+1 cycles, quotient truncated toward zero, sign-extended to WIDTH+1 bits, flags per REQ-022/023.
REQ-032 With ALU_SEQ_DIV_EN defined, divide by zero yields out=0 and flags=0101 (zero and overflow set).
REQ-033 Macro ALU_SEQ_DIV_EN undefined: op 110 is unsupported (out=0, flags=0100, latency 1) and no divider logic is synthesised.

Verification (WIDTH=16)
REQ-034 ADD 0x7FFF+0x0001 -> out 0x8000, flags 1001, out_valid one edge after accept.
REQ-035 MUL 0x0100*0x0100 -> out 0x0000, flags 0011, latency 18; MUL 0xFFFD*0x0004 -> out 0xFFF4, flags 1010.
REQ-036 DIV_EN: DIV 0xFFF9/0x0002 -> out 0xFFFD, flags 1010; DIV 0x0005/0x0000 -> out 0x0000, flags 0101; without DIV_EN, op 110 -> out 0x0000, flags 0100, latency 1.
REQ-037 SUB 5-5 with out_ready low for 5 cycles -> out 0x0000, flags 0100 held stable, in_ready 0, busy 1; release -> IDLE next edge.
REQ-038 rst pulse at BUSY cycle 7 of a MUL -> next cycle IDLE, out_valid 0, flags 0000; a following ADD 2+3 -> out 0x0005, flags 0000.
